operand_stack: RTL and testbench
================================

# operand_stack

Parametrised operand stack for the WebAssembly execution core. It replaces the single-TOS stack and exposes the top `PEEK` entries at once. It also supports compound pop-and-replace operations, so binary operators and `select` finish in one stack cycle instead of three. The execution core drives one operation per cycle and samples the registered outputs on the following cycle.

## Interface
- `WIDTH`, 66: entry width (2-bit type tag + 64-bit value).
- `DEPTH`, 8: maximum entries; ≥ 4.
- `PEEK`, 3: number of top entries visible; 1 ≤ `PEEK` ≤ `DEPTH`.
- `DW`, derived `$clog2(DEPTH+1)`: width of `depth`.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `op`  in  3: stack operation, sampled every rising edge.
- `data`  in  `WIDTH`: operand for `PUSH` and all `*REPLACE` ops.
- `peek`  out  `PEEK*WIDTH`: slice k (bits `[k*WIDTH +: WIDTH]`) holds entry k below top; k=0 is TOS.
- `depth`  out  `DW`: current entry count.
- `status`  out  2: `NORMAL`=0, `EMPTY`=1, `OVERFLOW`=2, `UNDERFLOW`=3. `status > EMPTY` means error.

## Operation
Ops and their effect (d = depth before the op, nd = depth after):
- `NONE`=0: no change.
- `PUSH`=1: requires d < `DEPTH`. New TOS = `data`; nd = d+1.
- `POP`=2: requires d ≥ 1. nd = d−1.
- `REPLACE`=3: requires d ≥ 1. TOS = `data`; nd = d.
- `POP1_REPLACE`=4: requires d ≥ 2. Removes TOS, then writes `data` into the new TOS; nd = d−1. Used by binary operators.
- `POP2_REPLACE`=5: requires d ≥ 3. Removes two entries, then writes `data` into the new TOS; nd = d−2. Used by `select`.
- `POP2`=6: requires d ≥ 2. nd = d−2.
- `7`: reserved; behaves as `NONE`.

Violations:
- Failed `PUSH` sets `OVERFLOW`.
- Any other failed requirement sets `UNDERFLOW`.
- On a violation, contents and `depth` are unchanged.

Error latching:
- An error status is sticky until `reset`.
- While in error, all ops are ignored, except that `peek` and `depth` stay valid.

Non-error status: `EMPTY` when nd = 0, otherwise `NORMAL`.

Peek slices:
- Slice k with k ≥ `depth` reads all-zero.
- The module never leaves stale data visible in slices k ≥ `depth`.

`data` is stored verbatim; the stack does no type checking.

## Timing
- Every op takes effect at the rising edge where it is sampled.
- `peek`, `depth` and `status` are registered and reflect the result one cycle later.
- Back-to-back ops are allowed every cycle. No stall or ready signal exists.
- Reset values:
  - `peek` = 0 and `depth` = 0.
  - `status` = `EMPTY`.
  - Storage contents are don't-care, but must be masked by the peek zeroing rule.
- `reset` has priority over `op` in the same cycle. An op sampled together with `reset` is discarded.
- Reset mid-sequence returns the stack to empty on the next cycle with no residual error.
- Boundary rules:
  - `PUSH` at d = `DEPTH`−1 reaches full depth with status `NORMAL`.
  - A further `PUSH` gives `OVERFLOW`.
  - `POP` at d = 1 gives `EMPTY`.
- Storage is indexed by a stack pointer, with no shifting. Write and read of the same slot in one op must yield the written value on the following cycle.

## Structure
- The shared package `stack_pkg` holds:
  - op encodings `NONE`…`POP2`;
  - status encodings;
  - type tags `i32`/`i64`/`f32`/`f64`, shared with the core.
- The core must import the op encodings from `stack_pkg` rather than redefine them.
- A single module, with no sub-module:
  - storage array `[DEPTH][WIDTH]`;
  - `DW`-bit pointer;
  - combinational next-state and legality logic;
  - output registers.
- Peek slices are built in a generate loop over `PEEK`.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `op=PUSH` held → `depth`=0, `status`=1, `peek`=0; no push is recorded.
- **Push and peek:** push 5, 6, 7 (`i32` tag) → `peek` slice0=7, slice1=6, slice2=5, `depth`=3. Then `POP2_REPLACE` with `data`=9 → `depth`=1, slice0=9, slices 1–2 = 0.
- **Fill and overflow:** push 8 entries → `depth`=8, `status`=0. A 9th `PUSH` → `status`=2, `depth`=8, TOS unchanged. A later `POP` is ignored.
- **Underflow:** after reset, `POP1_REPLACE` → `status`=3, `depth`=0. `reset` clears it to `status`=1.
- **Binary op:** push 3, push 4, `POP1_REPLACE` `data`=7 → `depth`=1, TOS=7.
- **Every-cycle streaming:** alternate `PUSH`/`REPLACE`/`POP` on consecutive cycles against a reference queue model → outputs match every cycle.
- **Parameter sweep:** repeat the above with `DEPTH`=4, `PEEK`=1 and `WIDTH`=34.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared encodings for the WebAssembly operand stack: stack ops, stack status
// and the value type tags that the execution core also uses.
package stack_pkg;

  typedef enum logic [2:0] {
    NONE         = 3'd0,
    PUSH         = 3'd1,
    POP          = 3'd2,
    REPLACE      = 3'd3,
    POP1_REPLACE = 3'd4,
    POP2_REPLACE = 3'd5,
    POP2         = 3'd6,
    OP_RESERVED  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    EMPTY     = 2'd1,
    OVERFLOW  = 2'd2,
    UNDERFLOW = 2'd3
  } status_e;

  localparam int TAG_W = 2;

  typedef enum logic [TAG_W-1:0] {
    TAG_I32 = 2'd0,
    TAG_I64 = 2'd1,
    TAG_F32 = 2'd2,
    TAG_F64 = 2'd3
  } type_tag_e;

endpackage

// File: rtl/operand_stack_if.sv
// Core-to-stack bus: one op per cycle in, registered peek/depth/status out.
// There is no valid/ready pair: the stack accepts op every clock and the core
// samples the outputs one cycle after driving an op.
interface operand_stack_if #(
  parameter int WIDTH = 66,
  parameter int PEEK  = 3,
  parameter int DW    = 4
);
  logic [2:0]            op;
  logic [WIDTH-1:0]      data;
  logic [PEEK*WIDTH-1:0] peek;
  logic [DW-1:0]         depth;
  logic [1:0]            status;

  modport master (output op, output data, input peek, input depth, input status);
  modport slave  (input op, input data, output peek, output depth, output status);
endinterface

// File: rtl/operand_stack.sv
// Pointer-indexed operand stack exposing the top PEEK entries, with compound
// pop-and-replace ops and a sticky overflow/underflow status.
module operand_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 66,
  parameter int DEPTH = 8,
  parameter int PEEK  = 3,
  localparam int DW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  operand_stack_if.slave  bus
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [DW-1:0] sp_q, sp_d;
  status_e       st_q, st_d;
  logic          wr_en;
  logic [AW-1:0] wr_ptr;
  logic          over, under;
  op_e           op;

  assign op = op_e'(bus.op);

  // State register: pointer (== depth) and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
      st_q <= EMPTY;
    end else begin
      sp_q <= sp_d;
      st_q <= st_d;
    end
  end

  // Next-state and legality. Candidate results are computed first, then
  // discarded wholesale on a violation or while an error is latched.
  always_comb begin
    logic [DW-1:0] sp_c;
    logic          wr_c;
    logic [AW-1:0] ptr_c;
    sp_c  = sp_q;
    wr_c  = 1'b0;
    ptr_c = '0;
    over  = 1'b0;
    under = 1'b0;
    case (op)
      PUSH: begin
        if (sp_q < DW'(DEPTH)) begin
          sp_c  = sp_q + DW'(1);
          wr_c  = 1'b1;
          ptr_c = AW'(sp_q);
        end else over = 1'b1;
      end
      POP: begin
        if (sp_q >= DW'(1)) sp_c = sp_q - DW'(1);
        else under = 1'b1;
      end
      REPLACE: begin
        if (sp_q >= DW'(1)) begin
          wr_c  = 1'b1;
          ptr_c = AW'(sp_q - DW'(1));
        end else under = 1'b1;
      end
      POP1_REPLACE: begin
        if (sp_q >= DW'(2)) begin
          sp_c  = sp_q - DW'(1);
          wr_c  = 1'b1;
          ptr_c = AW'(sp_q - DW'(2));
        end else under = 1'b1;
      end
      POP2_REPLACE: begin
        if (sp_q >= DW'(3)) begin
          sp_c  = sp_q - DW'(2);
          wr_c  = 1'b1;
          ptr_c = AW'(sp_q - DW'(3));
        end else under = 1'b1;
      end
      POP2: begin
        if (sp_q >= DW'(2)) sp_c = sp_q - DW'(2);
        else under = 1'b1;
      end
      default: ;
    endcase

    sp_d   = sp_q;
    st_d   = st_q;
    wr_en  = 1'b0;
    wr_ptr = ptr_c;
    if (st_q == OVERFLOW || st_q == UNDERFLOW) begin
      st_d = st_q;
    end else if (over) begin
      st_d = OVERFLOW;
    end else if (under) begin
      st_d = UNDERFLOW;
    end else begin
      sp_d  = sp_c;
      wr_en = wr_c;
      st_d  = (sp_c == '0) ? EMPTY : NORMAL;
    end
  end

  // Contents need no reset; slices above depth are masked at the peek register.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_ptr] <= bus.data;
  end

  // Peek slices are computed from the post-op pointer, forwarding the slot
  // being written this cycle so the new value appears on the next cycle.
  for (genvar k = 0; k < PEEK; k++) begin : g_peek
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] slice_d, slice_q;

    always_comb begin
      idx     = AW'(sp_d - DW'(k + 1));
      slice_d = '0;
      if (DW'(k) < sp_d) begin
        if (wr_en && (wr_ptr == idx)) slice_d = bus.data;
        else slice_d = mem[idx];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) slice_q <= '0;
      else slice_q <= slice_d;
    end

    assign bus.peek[k*WIDTH +: WIDTH] = slice_q;
  end

  // Output process.
  assign bus.depth  = sp_q;
  assign bus.status = st_q;

endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack: two instances (66x8x3 and 34x4x1) driven with the
// same op stream, each checked against its own queue reference model.
module tb_operand_stack;
  import stack_pkg::*;

  logic clk;
  logic reset;

  operand_stack_if #(.WIDTH(66), .PEEK(3), .DW(4)) bus_a ();
  operand_stack_if #(.WIDTH(34), .PEEK(1), .DW(3)) bus_b ();

  operand_stack #(.WIDTH(66), .DEPTH(8), .PEEK(3)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  operand_stack #(.WIDTH(34), .DEPTH(4), .PEEK(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference models and scoreboard
  logic [65:0]  mq_a[$];
  logic [65:0]  mq_b[$];
  logic [1:0]   ms_a, ms_b;
  logic [203:0] exp_a_q[$];
  logic [38:0]  exp_b_q[$];
  int           passed = 0;
  int           total  = 0;

  task automatic model_step(ref logic [65:0] q[$], ref logic [1:0] st, input int maxd,
                            input logic [2:0] op, input logic [65:0] d, input logic rst);
    if (rst) begin
      q.delete();
      st = EMPTY;
      return;
    end
    if (st >= OVERFLOW) return;
    case (op)
      PUSH:         if (q.size() < maxd) q.push_back(d); else st = OVERFLOW;
      POP:          if (q.size() >= 1) void'(q.pop_back()); else st = UNDERFLOW;
      REPLACE:      if (q.size() >= 1) q[q.size()-1] = d; else st = UNDERFLOW;
      POP1_REPLACE: if (q.size() >= 2) begin
                      void'(q.pop_back());
                      q[q.size()-1] = d;
                    end else st = UNDERFLOW;
      POP2_REPLACE: if (q.size() >= 3) begin
                      void'(q.pop_back());
                      void'(q.pop_back());
                      q[q.size()-1] = d;
                    end else st = UNDERFLOW;
      POP2:         if (q.size() >= 2) begin
                      void'(q.pop_back());
                      void'(q.pop_back());
                    end else st = UNDERFLOW;
      default: ;
    endcase
    if (st < OVERFLOW) st = (q.size() == 0) ? EMPTY : NORMAL;
  endtask

  function automatic logic [203:0] exp_a();
    logic [197:0] p;
    p = '0;
    for (int k = 0; k < 3; k++)
      if (k < mq_a.size()) p[k*66 +: 66] = mq_a[mq_a.size()-1-k];
    return {p, 4'(mq_a.size()), ms_a};
  endfunction

  function automatic logic [38:0] exp_b();
    logic [33:0] p;
    p = '0;
    if (mq_b.size() > 0) p = mq_b[mq_b.size()-1][33:0];
    return {p, 3'(mq_b.size()), ms_b};
  endfunction

  // Driver: apply one op to both DUTs for one clock, record expectations.
  task automatic drive(input logic [2:0] op, input logic [65:0] d, input logic rst);
    reset      = rst;
    bus_a.op   = op;
    bus_a.data = d;
    bus_b.op   = op;
    bus_b.data = d[33:0];
    model_step(mq_a, ms_a, 8, op, d, rst);
    model_step(mq_b, ms_b, 4, op, {32'b0, d[33:0]}, rst);
    exp_a_q.push_back(exp_a());
    exp_b_q.push_back(exp_b());
    @(posedge clk);
    #1;
  endtask

  function automatic logic [65:0] rnd_data();
    return {2'($urandom_range(0, 3)), 32'($urandom()), 32'($urandom())};
  endfunction

  task automatic test_reset();
    logic [203:0] ea;
    logic [38:0]  eb;
    for (int i = 0; i < 2; i++) begin
      drive(PUSH, {TAG_I32, 64'd42}, 1'b1);
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      total++;
      if ({bus_a.peek, bus_a.depth, bus_a.status} !== ea)
        $display("FAIL reset_a: got %h exp %h", {bus_a.peek, bus_a.depth, bus_a.status}, ea);
      else passed++;
      total++;
      if ({bus_b.peek, bus_b.depth, bus_b.status} !== eb)
        $display("FAIL reset_b: got %h exp %h", {bus_b.peek, bus_b.depth, bus_b.status}, eb);
      else passed++;
    end
    total++;
    if (bus_a.depth !== 4'd0 || bus_a.status !== 2'd1 || bus_a.peek !== '0)
      $display("FAIL reset_direct: depth %0d status %0d peek %h, exp 0/1/0",
               bus_a.depth, bus_a.status, bus_a.peek);
    else passed++;
  endtask

  task automatic test_push_peek();
    logic [2:0]   ops[4] = '{PUSH, PUSH, PUSH, POP2_REPLACE};
    logic [63:0]  vals[4] = '{64'd5, 64'd6, 64'd7, 64'd9};
    logic [203:0] ea;
    logic [38:0]  eb;
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], {TAG_I32, vals[i]}, 1'b0);
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      total++;
      if ({bus_a.peek, bus_a.depth, bus_a.status} !== ea)
        $display("FAIL push_peek_a[%0d]: got %h exp %h", i, {bus_a.peek, bus_a.depth, bus_a.status}, ea);
      else passed++;
      total++;
      if ({bus_b.peek, bus_b.depth, bus_b.status} !== eb)
        $display("FAIL push_peek_b[%0d]: got %h exp %h", i, {bus_b.peek, bus_b.depth, bus_b.status}, eb);
      else passed++;
      if (i == 2) begin
        total++;
        if (bus_a.peek !== {66'd5, 66'd6, 66'd7} || bus_a.depth !== 4'd3)
          $display("FAIL peek3_direct: got %h depth %0d exp slices 7,6,5 depth 3", bus_a.peek, bus_a.depth);
        else passed++;
      end
    end
    total++;
    if (bus_a.peek !== {66'd0, 66'd0, 66'd9} || bus_a.depth !== 4'd1)
      $display("FAIL pop2_replace_direct: got %h depth %0d exp 9,0,0 depth 1", bus_a.peek, bus_a.depth);
    else passed++;
  endtask

  task automatic test_fill_overflow();
    logic [65:0]  tos;
    logic [203:0] ea;
    logic [38:0]  eb;
    drive(NONE, '0, 1'b1);
    void'(exp_a_q.pop_front());
    void'(exp_b_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      if (i == 8) tos = bus_a.peek[65:0];
      drive((i == 9) ? POP : PUSH, rnd_data(), 1'b0);
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      total++;
      if ({bus_a.peek, bus_a.depth, bus_a.status} !== ea)
        $display("FAIL fill_a[%0d]: got %h exp %h", i, {bus_a.peek, bus_a.depth, bus_a.status}, ea);
      else passed++;
      total++;
      if ({bus_b.peek, bus_b.depth, bus_b.status} !== eb)
        $display("FAIL fill_b[%0d]: got %h exp %h", i, {bus_b.peek, bus_b.depth, bus_b.status}, eb);
      else passed++;
      if (i == 7) begin
        total++;
        if (bus_a.depth !== 4'd8 || bus_a.status !== 2'd0)
          $display("FAIL full_direct: depth %0d status %0d exp 8/0", bus_a.depth, bus_a.status);
        else passed++;
      end
      if (i >= 8) begin
        total++;
        if (bus_a.depth !== 4'd8 || bus_a.status !== 2'd2 || bus_a.peek[65:0] !== tos)
          $display("FAIL overflow_direct[%0d]: depth %0d status %0d tos %h exp 8/2/%h",
                   i, bus_a.depth, bus_a.status, bus_a.peek[65:0], tos);
        else passed++;
      end
    end
  endtask

  task automatic test_underflow();
    logic [2:0]   ops[4] = '{NONE, POP1_REPLACE, PUSH, NONE};
    logic         rsts[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]   want_a[4] = '{2'd1, 2'd3, 2'd3, 2'd1};
    logic [203:0] ea;
    logic [38:0]  eb;
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], {TAG_I64, 64'd11}, rsts[i]);
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      total++;
      if ({bus_a.peek, bus_a.depth, bus_a.status} !== ea)
        $display("FAIL underflow_a[%0d]: got %h exp %h", i, {bus_a.peek, bus_a.depth, bus_a.status}, ea);
      else passed++;
      total++;
      if ({bus_b.peek, bus_b.depth, bus_b.status} !== eb)
        $display("FAIL underflow_b[%0d]: got %h exp %h", i, {bus_b.peek, bus_b.depth, bus_b.status}, eb);
      else passed++;
      total++;
      if (bus_a.status !== want_a[i] || bus_a.depth !== 4'd0)
        $display("FAIL underflow_direct[%0d]: status %0d depth %0d exp %0d/0",
                 i, bus_a.status, bus_a.depth, want_a[i]);
      else passed++;
    end
  endtask

  task automatic test_binary_op();
    logic [2:0]   ops[3] = '{PUSH, PUSH, POP1_REPLACE};
    logic [63:0]  vals[3] = '{64'd3, 64'd4, 64'd7};
    logic [203:0] ea;
    logic [38:0]  eb;
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], {TAG_F64, vals[i]}, 1'b0);
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      total++;
      if ({bus_a.peek, bus_a.depth, bus_a.status} !== ea)
        $display("FAIL binop_a[%0d]: got %h exp %h", i, {bus_a.peek, bus_a.depth, bus_a.status}, ea);
      else passed++;
      total++;
      if ({bus_b.peek, bus_b.depth, bus_b.status} !== eb)
        $display("FAIL binop_b[%0d]: got %h exp %h", i, {bus_b.peek, bus_b.depth, bus_b.status}, eb);
      else passed++;
    end
    total++;
    if (bus_a.depth !== 4'd1 || bus_a.peek[65:0] !== {TAG_F64, 64'd7} || bus_b.peek !== 34'd7)
      $display("FAIL binop_direct: depth %0d tos %h b_tos %h exp 1/%h/7",
               bus_a.depth, bus_a.peek[65:0], bus_b.peek, {TAG_F64, 64'd7});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]   pat[8] = '{PUSH, REPLACE, PUSH, POP, PUSH, REPLACE, POP1_REPLACE, POP};
    logic [2:0]   op;
    logic         rst;
    logic [203:0] ea;
    logic [38:0]  eb;
    for (int i = 0; i < 340; i++) begin
      rst = 1'b0;
      if (i < 40) op = pat[i % 8];
      else if (ms_a >= 2'd2 || ms_b >= 2'd2) begin
        op  = PUSH;
        rst = 1'b1;
      end else op = 3'($urandom_range(0, 7));
      drive(op, rnd_data(), rst);
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      total++;
      if ({bus_a.peek, bus_a.depth, bus_a.status} !== ea)
        $display("FAIL stream_a[%0d] op %0d: got %h exp %h", i, op, {bus_a.peek, bus_a.depth, bus_a.status}, ea);
      else passed++;
      total++;
      if ({bus_b.peek, bus_b.depth, bus_b.status} !== eb)
        $display("FAIL stream_b[%0d] op %0d: got %h exp %h", i, op, {bus_b.peek, bus_b.depth, bus_b.status}, eb);
      else passed++;
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus_a.op   = NONE;
    bus_a.data = '0;
    bus_b.op   = NONE;
    bus_b.data = '0;
    ms_a       = EMPTY;
    ms_b       = EMPTY;
    test_reset();
    test_push_peek();
    test_fill_overflow();
    test_underflow();
    test_binary_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
